// File: rtl/score_bcd_formatter.sv
// Sequential 14-bit binary to 4-digit packed BCD formatter (double dabble) with a one-deep pending request.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits through LEs; otherwise LEs is tied to zero.
module score_bcd_formatter #(
    parameter int unsigned MAX_VALUE = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [13:0] value,
    output logic [15:0] hexs,
    output logic [3:0]  LEs,
    output logic        busy,
    output logic        done,
    output logic        ovf
);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    localparam logic [13:0] MaxVal = 14'(MAX_VALUE);

    state_t      state, nextState;
    logic [13:0] binReg, pendValue, inCapped;
    logic [15:0] scratch, adj;
    logic [3:0]  cnt;
    logic        satReg, pendValid, pendSat, inSat;
    logic        startLive, startPend, doShift, doCommit, storePend;

    assign inSat    = (value > MaxVal);
    assign inCapped = inSat ? MaxVal : value;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (load) nextState = SHIFT;
            SHIFT:   if (cnt == 4'd13) nextState = COMMIT;
            COMMIT:  nextState = (load || pendValid) ? SHIFT : IDLE;
            default: nextState = IDLE;
        endcase
    end

    // A live load in COMMIT is newer than anything pending, so it wins.
    always_comb begin
        startLive = load && (state == IDLE || state == COMMIT);
        startPend = (state == COMMIT) && !load && pendValid;
        doShift   = (state == SHIFT);
        doCommit  = (state == COMMIT);
        storePend = load && (state == SHIFT);
        busy      = (state != IDLE) || done;
    end

    always_comb begin
        adj = scratch;
        for (int unsigned i = 0; i < 4; i++) begin
            if (scratch[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            binReg    <= '0;
            scratch   <= '0;
            cnt       <= '0;
            satReg    <= 1'b0;
            pendValid <= 1'b0;
            pendValue <= '0;
            pendSat   <= 1'b0;
            hexs      <= '0;
            ovf       <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= doCommit;
            if (startLive) begin
                binReg  <= inCapped;
                satReg  <= inSat;
                scratch <= '0;
                cnt     <= '0;
            end else if (startPend) begin
                binReg  <= pendValue;
                satReg  <= pendSat;
                scratch <= '0;
                cnt     <= '0;
            end else if (doShift) begin
                {scratch, binReg} <= {adj, binReg} << 1;
                cnt               <= cnt + 4'd1;
            end
            if (storePend) begin
                pendValid <= 1'b1;
                pendValue <= inCapped;
                pendSat   <= inSat;
            end else if (startLive || startPend) begin
                pendValid <= 1'b0;
            end
            if (doCommit) begin
                hexs <= scratch;
                ovf  <= satReg;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            LEs <= 4'b1110;
        end else if (doCommit) begin
            LEs[3] <= (scratch[15:12] == 4'd0);
            LEs[2] <= (scratch[15:8] == 8'd0);
            LEs[1] <= (scratch[15:4] == 12'd0);
            LEs[0] <= 1'b0;
        end
    end
`else
    assign LEs = '0;
`endif

endmodule
